// File: rtl/e_mdu_if.sv
// e_mdu_if: operand/control/result bundle between the EX stage and the
// multiply/divide unit. The master drives operands and the op code; the slave
// (the MDU) returns Busy, the committed HI/LO and the mfhi/mflo read result.
interface e_mdu_if;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [3:0]  MDU_Ctr;
  logic        Start;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDU_Result;

  modport master (
    output SrcA, SrcB, MDU_Ctr, Start,
    input  Busy, HI, LO, MDU_Result
  );

  modport slave (
    input  SrcA, SrcB, MDU_Ctr, Start,
    output Busy, HI, LO, MDU_Result
  );
endinterface

// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit.
// The result is computed combinationally at launch and parked in tmp_hi/tmp_lo.
// A down-counter then models the fixed pipeline latency, and HI/LO are
// committed on the edge that takes the counter from 1 to 0.
// Busy comes from the state register, so it is glitch-free for the hazard unit.
// Optional feature macro: MDU_MADD_EN adds madd/maddu/msub/msubu (codes 9-12).
module e_mdu #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic   clk,
  input  logic   reset,
  e_mdu_if.slave mdu
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  localparam logic [3:0] CTR_MULT  = 4'd1;
  localparam logic [3:0] CTR_MULTU = 4'd2;
  localparam logic [3:0] CTR_DIV   = 4'd3;
  localparam logic [3:0] CTR_DIVU  = 4'd4;
  localparam logic [3:0] CTR_MFHI  = 4'd5;
  localparam logic [3:0] CTR_MFLO  = 4'd6;
  localparam logic [3:0] CTR_MTHI  = 4'd7;
  localparam logic [3:0] CTR_MTLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] CTR_MADD  = 4'd9;
  localparam logic [3:0] CTR_MADDU = 4'd10;
  localparam logic [3:0] CTR_MSUB  = 4'd11;
  localparam logic [3:0] CTR_MSUBU = 4'd12;
`endif

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      tmp_hi_q, tmp_hi_d, tmp_lo_q, tmp_lo_d;
  logic             wr_q, wr_d;

  logic signed [63:0] a_sx, b_sx, prod_sgn;
  logic [63:0]        prod_s, prod_u, acc;
  logic [31:0]        a_mag, b_mag, b_mag_safe, b_safe;
  logic [31:0]        q_mag, r_mag, q_sgn, r_sgn, q_uns, r_uns;

  logic             launch;
  logic [CNT_W-1:0] launch_cnt;
  logic [31:0]      res_hi, res_lo;
  logic             res_wr;

  // Datapath: products and quotients for every launchable op.
  // Signed divide works on magnitudes so -2^31 / -1 wraps cleanly.
  // A zero divisor is replaced by one so the divider never sees 0; that
  // result is never committed anyway.
  always_comb begin
    a_sx       = {{32{mdu.SrcA[31]}}, mdu.SrcA};
    b_sx       = {{32{mdu.SrcB[31]}}, mdu.SrcB};
    prod_sgn   = a_sx * b_sx;
    prod_s     = prod_sgn;
    prod_u     = {32'd0, mdu.SrcA} * {32'd0, mdu.SrcB};
    acc        = {hi_q, lo_q};
    a_mag      = mdu.SrcA[31] ? (32'd0 - mdu.SrcA) : mdu.SrcA;
    b_mag      = mdu.SrcB[31] ? (32'd0 - mdu.SrcB) : mdu.SrcB;
    b_mag_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    b_safe     = (mdu.SrcB == 32'd0) ? 32'd1 : mdu.SrcB;
    q_mag      = a_mag / b_mag_safe;
    r_mag      = a_mag % b_mag_safe;
    q_sgn      = (mdu.SrcA[31] ^ mdu.SrcB[31]) ? (32'd0 - q_mag) : q_mag;
    r_sgn      = mdu.SrcA[31] ? (32'd0 - r_mag) : r_mag;
    q_uns      = mdu.SrcA / b_safe;
    r_uns      = mdu.SrcA % b_safe;
  end

  // Launch decode: selects the pending result, latency and whether it commits.
  always_comb begin
    launch     = 1'b0;
    launch_cnt = CNT_MULT;
    res_hi     = hi_q;
    res_lo     = lo_q;
    res_wr     = 1'b0;
    case (mdu.MDU_Ctr)
      CTR_MULT:  begin launch = 1'b1; {res_hi, res_lo} = prod_s; res_wr = 1'b1; end
      CTR_MULTU: begin launch = 1'b1; {res_hi, res_lo} = prod_u; res_wr = 1'b1; end
      CTR_DIV: begin
        launch = 1'b1; launch_cnt = CNT_DIV;
        res_hi = r_sgn; res_lo = q_sgn; res_wr = (mdu.SrcB != 32'd0);
      end
      CTR_DIVU: begin
        launch = 1'b1; launch_cnt = CNT_DIV;
        res_hi = r_uns; res_lo = q_uns; res_wr = (mdu.SrcB != 32'd0);
      end
`ifdef MDU_MADD_EN
      CTR_MADD:  begin launch = 1'b1; {res_hi, res_lo} = acc + prod_s; res_wr = 1'b1; end
      CTR_MADDU: begin launch = 1'b1; {res_hi, res_lo} = acc + prod_u; res_wr = 1'b1; end
      CTR_MSUB:  begin launch = 1'b1; {res_hi, res_lo} = acc - prod_s; res_wr = 1'b1; end
      CTR_MSUBU: begin launch = 1'b1; {res_hi, res_lo} = acc - prod_u; res_wr = 1'b1; end
`endif
      default:   launch = 1'b0;
    endcase
  end

  // Next-state: launch/mt* when idle, count down and commit when running.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    tmp_hi_d = tmp_hi_q;
    tmp_lo_d = tmp_lo_q;
    wr_d     = wr_q;
    case (state_q)
      S_IDLE: begin
        if (mdu.Start && launch) begin
          state_d  = S_RUN;
          cnt_d    = launch_cnt;
          tmp_hi_d = res_hi;
          tmp_lo_d = res_lo;
          wr_d     = res_wr;
        end else if (mdu.MDU_Ctr == CTR_MTHI) begin
          hi_d = mdu.SrcA;
        end else if (mdu.MDU_Ctr == CTR_MTLO) begin
          lo_d = mdu.SrcA;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_IDLE;
          if (wr_q) begin
            hi_d = tmp_hi_q;
            lo_d = tmp_lo_q;
          end else begin
            hi_d = hi_q;
          end
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State, counter, pending result and committed HI/LO; reset drops any pending op.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= CNT_ZERO;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      tmp_hi_q <= 32'd0;
      tmp_lo_q <= 32'd0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      tmp_hi_q <= tmp_hi_d;
      tmp_lo_q <= tmp_lo_d;
      wr_q     <= wr_d;
    end
  end

  // mfhi/mflo read port straight from the committed registers.
  always_comb begin
    case (mdu.MDU_Ctr)
      CTR_MFHI: mdu.MDU_Result = hi_q;
      CTR_MFLO: mdu.MDU_Result = lo_q;
      default:  mdu.MDU_Result = 32'd0;
    endcase
  end

  assign mdu.Busy = (state_q == S_RUN);
  assign mdu.HI   = hi_q;
  assign mdu.LO   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: self-checking bench for e_mdu with a behavioural HI/LO model.
// Define MDU_MADD_EN for both bench and RTL to exercise the madd family.
module tb_e_mdu;
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] hi_m, lo_m;

  e_mdu_if mif();

  e_mdu #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (mif)
  );

  always #5 clk = ~clk;

  // Reference: HI/LO after an op, from plain 64-bit arithmetic.
  function automatic void model(input logic [3:0] ctr, input logic [31:0] a, b, hi, lo,
                                output logic [31:0] nh, nl, output int lat);
    longint          sa, sb, q, r;
    longint unsigned ua, ub;
    logic [63:0]     p, acc;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    acc = {hi, lo};
    nh = hi; nl = lo; lat = 0;
    case (ctr)
      4'd1: begin p = sa * sb; {nh, nl} = p; lat = MULT_LAT; end
      4'd2: begin p = ua * ub; {nh, nl} = p; lat = MULT_LAT; end
      4'd3: begin
        lat = DIV_LAT;
        if (b != 32'd0) begin q = sa / sb; r = sa % sb; nl = q[31:0]; nh = r[31:0]; end
      end
      4'd4: begin
        lat = DIV_LAT;
        if (b != 32'd0) begin p = ua / ub; nl = p[31:0]; p = ua % ub; nh = p[31:0]; end
      end
`ifdef MDU_MADD_EN
      4'd9:  begin p = sa * sb; {nh, nl} = acc + p; lat = MULT_LAT; end
      4'd10: begin p = ua * ub; {nh, nl} = acc + p; lat = MULT_LAT; end
      4'd11: begin p = sa * sb; {nh, nl} = acc - p; lat = MULT_LAT; end
      4'd12: begin p = ua * ub; {nh, nl} = acc - p; lat = MULT_LAT; end
`endif
      default: lat = 0;
    endcase
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // Launch from a negedge with Busy low; ends on the negedge that sees Busy fall.
  task automatic run_op(input logic [3:0] ctr, input logic [31:0] a, b, input string name);
    logic [31:0] eh, el;
    int lat, n;
    model(ctr, a, b, hi_m, lo_m, eh, el, lat);
    mif.Start = 1'b1; mif.MDU_Ctr = ctr; mif.SrcA = a; mif.SrcB = b;
    @(negedge clk);
    mif.Start = 1'b0; mif.MDU_Ctr = 4'd0;
    n = 0;
    while (mif.Busy === 1'b1 && n < 64) begin
      n++;
      if (n == 1) begin
        mif.MDU_Ctr = 4'd5; #1;
        checks++;
        if (mif.MDU_Result !== hi_m)
          $display("FAIL %s mfhi_during_busy got %h exp %h", name, mif.MDU_Result, hi_m);
        if (mif.MDU_Result !== hi_m) errors++;
        mif.MDU_Ctr = 4'd0;
      end
      @(negedge clk);
    end
    checks++;
    if (n !== lat) begin errors++; $display("FAIL %s busy_cycles got %0d exp %0d", name, n, lat); end
    checks++;
    if (mif.HI !== eh || mif.LO !== el) begin
      errors++;
      $display("FAIL %s hilo got %h:%h exp %h:%h", name, mif.HI, mif.LO, eh, el);
    end
    hi_m = eh; lo_m = el;
  endtask

  task automatic do_mt(input logic [3:0] ctr, input logic [31:0] a);
    mif.MDU_Ctr = ctr; mif.SrcA = a;
    @(negedge clk);
    mif.MDU_Ctr = 4'd0;
    if (ctr == 4'd7) hi_m = a;
    else lo_m = a;
  endtask

  task automatic check_mf(input string name);
    mif.MDU_Ctr = 4'd5; #1;
    checks++;
    if (mif.MDU_Result !== hi_m) begin errors++; $display("FAIL %s mfhi got %h exp %h", name, mif.MDU_Result, hi_m); end
    mif.MDU_Ctr = 4'd6; #1;
    checks++;
    if (mif.MDU_Result !== lo_m) begin errors++; $display("FAIL %s mflo got %h exp %h", name, mif.MDU_Result, lo_m); end
    mif.MDU_Ctr = 4'd0; #1;
    checks++;
    if (mif.MDU_Result !== 32'd0) begin errors++; $display("FAIL %s result_none got %h exp 0", name, mif.MDU_Result); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (mif.Busy !== 1'b0 || mif.HI !== 32'd0 || mif.LO !== 32'd0) begin
      errors++; $display("FAIL reset busy/hi/lo got %b %h %h exp 0 0 0", mif.Busy, mif.HI, mif.LO);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (mif.Busy !== 1'b0) begin errors++; $display("FAIL reset_release busy got %b exp 0", mif.Busy); end
    hi_m = 32'd0; lo_m = 32'd0;
  endtask

  task automatic test_directed();
    run_op(4'd1, 32'hFFFF_FFFF, 32'd2, "mult_m1x2");
    checks++;
    if (mif.HI !== 32'hFFFF_FFFF || mif.LO !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL mult_const got %h:%h exp ffffffff:fffffffe", mif.HI, mif.LO);
    end
    run_op(4'd2, 32'hFFFF_FFFF, 32'd2, "multu_max_x2");
    checks++;
    if (mif.HI !== 32'h0000_0001 || mif.LO !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL multu_const got %h:%h exp 00000001:fffffffe", mif.HI, mif.LO);
    end
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    checks++;
    if (mif.HI !== 32'hFFFF_FFFF || mif.LO !== 32'hFFFF_FFFD) begin
      errors++; $display("FAIL div_const got %h:%h exp ffffffff:fffffffd", mif.HI, mif.LO);
    end
    run_op(4'd4, 32'd7, 32'd0, "divu_by_zero");
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    checks++;
    if (mif.HI !== 32'd0 || mif.LO !== 32'h8000_0000) begin
      errors++; $display("FAIL div_overflow_const got %h:%h exp 00000000:80000000", mif.HI, mif.LO);
    end
    run_op(4'd4, 32'hFFFF_FFF9, 32'd2, "divu_big");
  endtask

  task automatic test_mt_mf();
    do_mt(4'd7, 32'h1234_5678);
    mif.MDU_Ctr = 4'd5; #1;
    checks++;
    if (mif.MDU_Result !== 32'h1234_5678) begin
      errors++; $display("FAIL mthi_mfhi got %h exp 12345678", mif.MDU_Result);
    end
    mif.MDU_Ctr = 4'd0;
    do_mt(4'd8, 32'h9ABC_DEF0);
    check_mf("mt_mf");
  endtask

  // Inject a launch or mt* while a mult is in flight; it must have no effect.
  task automatic test_busy_ignore(input logic [3:0] inj);
    logic [31:0] a, b, eh, el;
    int lat, n;
    a = $urandom; b = $urandom;
    model(4'd1, a, b, hi_m, lo_m, eh, el, lat);
    mif.Start = 1'b1; mif.MDU_Ctr = 4'd1; mif.SrcA = a; mif.SrcB = b;
    @(negedge clk);
    mif.Start = 1'b0; mif.MDU_Ctr = 4'd0;
    n = 0;
    while (mif.Busy === 1'b1 && n < 64) begin
      n++;
      if (n == 2) begin
        mif.Start = (inj < 4'd5); mif.MDU_Ctr = inj; mif.SrcA = $urandom; mif.SrcB = 32'd3;
      end else begin
        mif.Start = 1'b0; mif.MDU_Ctr = 4'd0;
      end
      @(negedge clk);
    end
    mif.Start = 1'b0; mif.MDU_Ctr = 4'd0;
    checks++;
    if (n !== lat) begin errors++; $display("FAIL busy_ignore_%0d cycles got %0d exp %0d", inj, n, lat); end
    checks++;
    if (mif.HI !== eh || mif.LO !== el) begin
      errors++; $display("FAIL busy_ignore_%0d hilo got %h:%h exp %h:%h", inj, mif.HI, mif.LO, eh, el);
    end
    hi_m = eh; lo_m = el;
  endtask

  task automatic test_invalid();
`ifdef MDU_MADD_EN
    logic [3:0] codes [6] = '{4'd0, 4'd5, 4'd6, 4'd13, 4'd14, 4'd15};
`else
    logic [3:0] codes [10] = '{4'd0, 4'd5, 4'd6, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
`endif
    foreach (codes[i]) begin
      mif.Start = 1'b1; mif.MDU_Ctr = codes[i]; mif.SrcA = $urandom; mif.SrcB = $urandom;
      @(negedge clk);
      mif.Start = 1'b0; mif.MDU_Ctr = 4'd0;
      checks++;
      if (mif.Busy !== 1'b0 || mif.HI !== hi_m || mif.LO !== lo_m) begin
        errors++;
        $display("FAIL invalid_%0d busy/hi/lo got %b %h %h exp 0 %h %h", codes[i], mif.Busy, mif.HI, mif.LO, hi_m, lo_m);
      end
    end
  endtask

  task automatic test_back_to_back();
    run_op(4'd2, 32'd100000, 32'd300000, "b2b_multu");
    run_op(4'd3, 32'd1000, 32'hFFFF_FFFD, "b2b_div");
    run_op(4'd1, 32'h8000_0000, 32'h8000_0000, "b2b_mult");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    int sel;
    for (int k = 0; k < 40; k++) begin
      sel = $urandom_range(0, 5);
      a = rnd_operand();
      b = rnd_operand();
      if (sel < 4) run_op(4'(sel + 1), a, b, "rand_op");
      else begin
        do_mt((sel == 4) ? 4'd7 : 4'd8, a);
        check_mf("rand_mt");
      end
    end
  endtask

`ifdef MDU_MADD_EN
  task automatic test_madd();
    do_mt(4'd7, 32'd0);
    do_mt(4'd8, 32'd5);
    run_op(4'd9, 32'd3, 32'd4, "madd");
    checks++;
    if (mif.HI !== 32'd0 || mif.LO !== 32'd17) begin errors++; $display("FAIL madd_const got %h:%h exp 0:17", mif.HI, mif.LO); end
    run_op(4'd12, 32'd1, 32'd18, "msubu");
    checks++;
    if (mif.HI !== 32'hFFFF_FFFF || mif.LO !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL msubu_const got %h:%h exp ffffffff:ffffffff", mif.HI, mif.LO);
    end
    for (int k = 0; k < 12; k++) run_op(4'($urandom_range(9, 12)), rnd_operand(), rnd_operand(), "rand_madd");
  endtask
`endif

  task automatic test_reset_mid_op();
    bit seen;
    do_mt(4'd7, 32'hCAFE_BABE);
    do_mt(4'd8, 32'h0BAD_F00D);
    mif.Start = 1'b1; mif.MDU_Ctr = 4'd3; mif.SrcA = 32'd100; mif.SrcB = 32'd7;
    @(negedge clk);
    mif.Start = 1'b0; mif.MDU_Ctr = 4'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (mif.Busy !== 1'b1) begin errors++; $display("FAIL midreset_pre busy got %b exp 1", mif.Busy); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (mif.Busy !== 1'b0 || mif.HI !== 32'd0 || mif.LO !== 32'd0) begin
      errors++; $display("FAIL midreset busy/hi/lo got %b %h %h exp 0 0 0", mif.Busy, mif.HI, mif.LO);
    end
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (DIV_LAT + 5) begin
      @(negedge clk);
      if (mif.Busy !== 1'b0 || mif.HI !== 32'd0 || mif.LO !== 32'd0) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL midreset_no_commit got late activity exp none"); end
    hi_m = 32'd0; lo_m = 32'd0;
  endtask

  initial begin
    reset = 1'b0;
    mif.Start = 1'b0; mif.MDU_Ctr = 4'd0; mif.SrcA = 32'd0; mif.SrcB = 32'd0;
    test_reset();
    test_directed();
    test_mt_mf();
    test_busy_ignore(4'd3);
    test_busy_ignore(4'd7);
    test_busy_ignore(4'd8);
    test_invalid();
    test_back_to_back();
    test_random();
`ifdef MDU_MADD_EN
    test_madd();
`endif
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end
endmodule
